// File: rtl/obs_sched.sv
// obs_sched: round-based scheduler that walks enabled channels through a shared observer.
// Ports: clk, rst (async, active-high); en gates the period counter; ch_en selects channels per round;
// obs_req/obs_ch/obs_ack form the observer handshake; busy marks an active round; round_done pulses at its end;
// overrun_cnt counts ticks lost to a busy round (saturating); timeout_err holds sticky per-channel ack timeouts.
// Optional: define OBS_SCHED_TIMEOUT_EN to abandon a channel after TIMEOUT cycles without an ack.
module obs_sched #(
  parameter int N_CH    = 4,
  parameter int PERIOD  = 2**22,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_CH-1:0]         ch_en,
  output logic                    obs_req,
  output logic [$clog2(N_CH)-1:0] obs_ch,
  input  logic                    obs_ack,
  output logic                    busy,
  output logic                    round_done,
  output logic [7:0]              overrun_cnt,
  output logic [N_CH-1:0]         timeout_err
);
  localparam int CW = $clog2(N_CH);
  localparam int PW = $clog2(PERIOD);
  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;
  state_t state, nxt;
  logic [PW-1:0] cnt;
  logic [N_CH-1:0] pnd, pnd_n;
  logic tick, hs, to, fin;
  function automatic logic [CW-1:0] lsb(input logic [N_CH-1:0] m);
    lsb = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (m[i]) lsb = CW'(i);
  endfunction
  assign tick = en && cnt == PW'(PERIOD - 1);
  assign hs   = state == REQ && obs_ack;
  assign fin  = hs || to;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (!en || tick) ? '0 : cnt + 1'b1;
`ifdef OBS_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wcnt;
  // wcnt is 0 in the first REQ cycle, so the give-up edge ends the TIMEOUT-th cycle in REQ
  assign to = state == REQ && wcnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wcnt        <= '0;
      timeout_err <= '0;
    end else begin
      wcnt <= (state == REQ) ? wcnt + 1'b1 : '0;
      if (to && !obs_ack) timeout_err[obs_ch] <= 1'b1;
    end
`else
  assign to          = 1'b0;
  assign timeout_err = '0;
`endif
  always_comb begin
    nxt   = state;
    pnd_n = pnd;
    case (state)
      IDLE: if (tick && |ch_en) begin
        pnd_n = ch_en;
        nxt   = REQ;
      end
      REQ: if (fin) begin
        pnd_n = pnd & ~(N_CH'(1) << obs_ch);
        nxt   = |pnd_n ? GAP : DONE;
      end
      GAP:     nxt = REQ;
      default: nxt = IDLE;
    endcase
  end
  // outputs are registered from the next-state decode so they line up with the state they describe
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= IDLE;
      pnd         <= '0;
      obs_req     <= 1'b0;
      obs_ch      <= '0;
      busy        <= 1'b0;
      round_done  <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state      <= nxt;
      pnd        <= pnd_n;
      obs_req    <= nxt == REQ;
      obs_ch     <= (nxt == REQ) ? lsb(pnd_n) : obs_ch;
      busy       <= nxt != IDLE;
      round_done <= nxt == DONE;
      if (tick && busy && overrun_cnt != 8'hff) overrun_cnt <= overrun_cnt + 1'b1;
    end
endmodule

// File: tb/tb_obs_sched.sv
// tb_obs_sched: directed self-checking bench for obs_sched (N_CH=4, PERIOD=16, TIMEOUT=8).
module tb_obs_sched;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, obs_ack = 1'b0;
  logic [3:0] ch_en = '0;
  logic obs_req, busy, round_done;
  logic [1:0] obs_ch;
  logic [7:0] overrun_cnt;
  logic [3:0] timeout_err;
  int total = 0, bad = 0, n;
  obs_sched #(.N_CH(4), .PERIOD(16), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en), .obs_req(obs_req), .obs_ch(obs_ch),
    .obs_ack(obs_ack), .busy(busy), .round_done(round_done), .overrun_cnt(overrun_cnt),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic wait_req(output int k);
    k = 0;
    while (obs_req !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
  endtask
  task automatic do_hs(input logic [1:0] c);
    chk("hs_req", obs_req, 1);
    chk("hs_ch", obs_ch, c);
    step(1);
    chk("hs_hold", obs_ch, c);
    obs_ack = 1'b1;
    step(1);
    obs_ack = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_req", obs_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", round_done, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    en = 1'b1;
    ch_en = 4'b1011;
    wait_req(n);
    chk("lat_first", n, 16);
    do_hs(2'd0);
    chk("gap0_req", obs_req, 0);
    chk("gap0_busy", busy, 1);
    step(1);
    do_hs(2'd1);
    chk("gap1_req", obs_req, 0);
    step(1);
    do_hs(2'd3);
    chk("done_pulse", round_done, 1);
    chk("done_req", obs_req, 0);
    step(1);
    chk("done_end", round_done, 0);
    chk("idle_busy", busy, 0);
    ch_en = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("empty_req", obs_req, 0);
      chk("empty_busy", busy, 0);
      chk("empty_done", round_done, 0);
    end
    ch_en = 4'b0001;
    wait_req(n);
    chk("ovr_req", obs_req, 1);
    step(20);
    chk("ovr_hold", obs_req, 1);
    chk("ovr_cnt", overrun_cnt, 1);
    chk("ovr_nodone", round_done, 0);
    obs_ack = 1'b1;
    step(1);
    obs_ack = 1'b0;
    chk("ovr_done", round_done, 1);
    step(1);
    chk("ovr_single", round_done, 0);
    ch_en = 4'b0100;
    wait_req(n);
    chk("to_req", obs_req, 1);
    chk("to_ch", obs_ch, 2);
`ifdef OBS_SCHED_TIMEOUT_EN
    step(7);
    chk("to_wait", obs_req, 1);
    chk("to_noerr", timeout_err, 0);
    step(1);
    chk("to_drop", obs_req, 0);
    chk("to_done", round_done, 1);
    chk("to_err", timeout_err, 4'b0100);
    step(1);
    chk("to_sticky", timeout_err, 4'b0100);
`else
    step(20);
    chk("nto_hold", obs_req, 1);
    chk("nto_err", timeout_err, 0);
    obs_ack = 1'b1;
    step(1);
    obs_ack = 1'b0;
    chk("nto_done", round_done, 1);
`endif
    wait_req(n);
    chk("mid_req", obs_req, 1);
    obs_ack = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("arst_req", obs_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ch", obs_ch, 0);
    chk("arst_done", round_done, 0);
    chk("arst_ovr", overrun_cnt, 0);
    chk("arst_terr", timeout_err, 0);
    step(1);
    obs_ack = 1'b0;
    rst = 1'b0;
    ch_en = 4'b1011;
    wait_req(n);
    chk("lat_rst", n, 16);
    ch_en = 4'b0000;
    do_hs(2'd0);
    en = 1'b0;
    chk("late_gap", obs_req, 0);
    step(1);
    do_hs(2'd1);
    step(1);
    do_hs(2'd3);
    chk("late_done", round_done, 1);
    step(1);
    chk("late_idle", busy, 0);
    ch_en = 4'b1011;
    for (int i = 0; i < 40; i++) begin
      step(1);
      chk("off_req", obs_req, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/obs_sched.md
OBS_SCHED -- requirements
Module: obs_sched

Interface
REQ-001 The block SHALL expose these parameters:
- N_CH, default 4, number of observation channels (2..16)
- PERIOD, default 2**22, cycles between observation rounds (>=4)
- TIMEOUT, default 255, maximum cycles spent waiting for an ack
REQ-002 The block SHALL expose these ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  enables the period counter and new rounds
- ch_en  in  N_CH  per-channel enable, sampled at tick
- obs_req  out  1  observation request to the shared observer
- obs_ch  out  $clog2(N_CH)  index of the channel being observed
- obs_ack  in  1  observer completion, one-cycle pulse
- busy  out  1  high while a round is in progress
- round_done  out  1  one-cycle pulse at the end of each round
- overrun_cnt  out  8  count of ticks dropped because busy; saturating
- timeout_err  out  N_CH  sticky per-channel ack-timeout flags

Function
REQ-003 The period counter SHALL count 0..PERIOD-1 while en=1, wrap to 0, and assert an internal tick in the cycle it equals PERIOD-1.
REQ-004 The period counter SHALL clear to 0 and hold while en=0.
REQ-005 The FSM SHALL have the states IDLE, REQ, GAP and DONE.
REQ-006 In IDLE, on a tick with ch_en!=0, the FSM SHALL capture ch_en into a pending mask and go to REQ.
REQ-007 In IDLE, a tick with ch_en==0 SHALL be ignored, with no round_done pulse.
REQ-008 In REQ, obs_req=1 and obs_ch SHALL equal the lowest set bit of the pending mask, held stable until the handshake completes.
REQ-009 A handshake SHALL complete at the rising edge where obs_req=1 and obs_ack=1.
REQ-010 On handshake completion, the channel's pending bit SHALL clear, and the FSM SHALL go to GAP if the mask is non-zero, otherwise to DONE.
REQ-011 obs_ack while obs_req=0 SHALL be ignored.
REQ-012 GAP SHALL last exactly 1 cycle with obs_req=0, then go to REQ.
REQ-013 DONE SHALL last 1 cycle with round_done=1, then go to IDLE.
REQ-014 Latency: obs_req SHALL rise in the cycle after the tick cycle.
REQ-015 busy SHALL be 1 in REQ, GAP and DONE.
REQ-016 A tick while busy=1 SHALL be dropped and overrun_cnt SHALL increment, saturating at 255.
REQ-017 ch_en changes mid-round SHALL NOT alter the captured pending mask.
REQ-018 en deasserted mid-round: the current round SHALL complete normally, and no new round SHALL start until en=1 and a fresh tick occurs.
REQ-019 All outputs SHALL be registered.

Reset
REQ-020 rst=1 SHALL, asynchronously, force:
- FSM to IDLE and period counter to 0
- pending mask to 0
- obs_req=0, obs_ch=0, busy=0, round_done=0
- overrun_cnt=0, timeout_err=0
REQ-021 After rst deasserts, the first tick SHALL occur PERIOD cycles after en is first sampled high.
REQ-022 Reset asserted mid-handshake SHALL abort the round, and any pending ack SHALL be discarded.

Configuration
REQ-023 With OBS_SCHED_TIMEOUT_EN defined, an ack-wait counter SHALL clear on entry to REQ and increment each cycle in REQ.
REQ-024 With OBS_SCHED_TIMEOUT_EN defined, when the ack-wait counter reaches TIMEOUT without an ack, the block SHALL:
- set timeout_err[obs_ch]
- clear that channel's pending bit
- proceed exactly as for a completed handshake
REQ-025 With OBS_SCHED_TIMEOUT_EN defined, an ack in the same cycle as the timeout SHALL win, and no error SHALL be set.
REQ-026 timeout_err bits SHALL clear only on reset.
REQ-027 Without OBS_SCHED_TIMEOUT_EN, REQ SHALL wait indefinitely for an ack, and timeout_err SHALL be tied to 0.

Verification
REQ-028 The bench SHALL cover these scenarios (PERIOD=16, N_CH=4, TIMEOUT=8):
- ch_en=4'b1011, obs_ack one cycle after each obs_req rise -> obs_ch sequence 0,1,3; obs_req low 1 cycle between requests; round_done once; obs_req first rises 16 cycles after en.
- ch_en=0 at tick -> no obs_req, no round_done, busy stays 0.
- Ack withheld for 20 cycles so a second tick hits while busy -> overrun_cnt=1; round still completes with a single round_done.
- Timeout build, no ack on ch2 with ch_en=4'b0100 -> after 8 cycles in REQ, timeout_err=4'b0100 and round_done pulses; non-timeout build -> obs_req stays high.
- rst pulsed while obs_req=1 -> all outputs 0 immediately; next round starts from ch0 after 16 cycles.
- ch_en toggled to 0 mid-round, then en=0 mid-round -> round completes on the original mask; no further ticks.
